// File: rtl/midi_pkg.sv
// MIDI note transmitter shared definitions: status nibbles, the buffered
// event record, FSM state types and a helper that forms message bytes.
package midi_pkg;

  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;

  typedef struct packed {
    logic       on;
    logic [3:0] channel;
    logic [6:0] note;
    logic [6:0] velocity;
  } midi_event_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } uart_state_t;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_SEND
  } seq_state_t;

  // Byte idx of the 3-byte message: 0 = status, 1 = note, 2 = velocity.
  function automatic logic [7:0] midi_byte(input midi_event_t ev, input logic [1:0] idx);
    case (idx)
      2'd0:    midi_byte = {(ev.on ? MIDI_NOTE_ON : MIDI_NOTE_OFF), ev.channel};
      2'd1:    midi_byte = {1'b0, ev.note};
      default: midi_byte = {1'b0, ev.velocity};
    endcase
  endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// 8N1 byte serializer for the MIDI line.
//   clk, reset  : system clock, synchronous active-high reset
//   byte_valid  : byte_data is offered; taken when idle or in the last
//                 cycle of a stop bit (byte_done), so bytes chain gap-free
//   byte_data   : byte to send, LSB first
//   byte_done   : high in the final cycle of the stop bit
//   txd         : registered serial output, idles high
module midi_uart_tx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 50_000_000,
  parameter int unsigned BAUD          = 31250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_done,
  output logic       txd
);

  localparam int unsigned DIV = CLK_FREQUENCY / BAUD;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  uart_state_t   state, state_n;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          txd_n;
  logic          bit_end;

  assign bit_end   = (baud_cnt == LAST);
  assign byte_done = (state == TX_STOP) && bit_end;

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    txd_n      = txd;
    if (byte_valid && ((state == TX_IDLE) || byte_done)) begin
      state_n    = TX_START;
      baud_cnt_n = '0;
      bit_cnt_n  = '0;
      shift_n    = byte_data;
      txd_n      = 1'b0;
    end else begin
      case (state)
        TX_IDLE: txd_n = 1'b1;
        TX_START: begin
          if (bit_end) begin
            baud_cnt_n = '0;
            state_n    = TX_DATA;
            txd_n      = shift[0];
          end else begin
            baud_cnt_n = baud_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            baud_cnt_n = '0;
            if (bit_cnt == 3'd7) begin
              state_n = TX_STOP;
              txd_n   = 1'b1;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
              shift_n   = {1'b0, shift[7:1]};
              txd_n     = shift[1];
            end
          end else begin
            baud_cnt_n = baud_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            baud_cnt_n = '0;
            state_n    = TX_IDLE;
            txd_n      = 1'b1;
          end else begin
            baud_cnt_n = baud_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      txd      <= txd_n;
    end
  end

endmodule

// File: rtl/midi_note_tx.sv
// Buffers note events in a small FIFO and sends each as a 3-byte MIDI
// Note On / Note Off message on the 31250-baud line.
//   clk, reset   : system clock, synchronous active-high reset
//   ev_valid/ev_ready : event handshake, accepted when both high
//   ev_on, ev_note, ev_velocity, ev_channel : event fields
//   midi_txd     : registered serial output, idles high
//   busy         : message in flight or FIFO non-empty
//   fifo_level   : number of stored events
module midi_note_tx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 50_000_000,
  parameter int unsigned BAUD          = 31250,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic                          ev_on,
  input  logic [6:0]                    ev_note,
  input  logic [6:0]                    ev_velocity,
  input  logic [3:0]                    ev_channel,
  output logic                          midi_txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

  midi_event_t mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  midi_event_t head;
  logic        push, pop;

  seq_state_t  seq, seq_n;
  logic [1:0]  bidx, bidx_n;
  midi_event_t msg;
  logic        byte_valid, byte_done;
  logic [7:0]  byte_data;

  assign fifo_level = wr_ptr - rd_ptr;
  assign ev_ready   = (fifo_level != FULL_LEVEL);
  assign push       = ev_valid && ev_ready;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign busy       = (seq != SEQ_IDLE) || (fifo_level != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {ev_on, ev_channel, ev_note, ev_velocity};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Next byte is offered in the serializer's final stop-bit cycle, and a
  // pop feeds the status byte straight from the FIFO head, so the line
  // never idles between bytes or queued messages.
  always_comb begin
    seq_n      = seq;
    bidx_n     = bidx;
    pop        = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    case (seq)
      SEQ_IDLE: begin
        if (fifo_level != '0) begin
          pop        = 1'b1;
          byte_valid = 1'b1;
          byte_data  = midi_byte(head, 2'd0);
          bidx_n     = '0;
          seq_n      = SEQ_SEND;
        end
      end
      SEQ_SEND: begin
        if (byte_done) begin
          if (bidx < 2'd2) begin
            bidx_n     = bidx + 2'd1;
            byte_valid = 1'b1;
            byte_data  = midi_byte(msg, bidx + 2'd1);
          end else if (fifo_level != '0) begin
            pop        = 1'b1;
            byte_valid = 1'b1;
            byte_data  = midi_byte(head, 2'd0);
            bidx_n     = '0;
          end else begin
            seq_n = SEQ_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq  <= SEQ_IDLE;
      bidx <= '0;
      msg  <= '0;
    end else begin
      seq  <= seq_n;
      bidx <= bidx_n;
      if (pop) msg <= head;
    end
  end

  midi_uart_tx #(
    .CLK_FREQUENCY(CLK_FREQUENCY),
    .BAUD         (BAUD)
  ) u_uart (
    .clk       (clk),
    .reset     (reset),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_done (byte_done),
    .txd       (midi_txd)
  );

endmodule

// File: tb/tb_midi_note_tx.sv
// Bench for midi_note_tx: a timeline model predicts line level, busy,
// fifo_level and ev_ready every cycle; a second instance checks the
// default bit rate.
module tb_midi_note_tx;
  import midi_pkg::*;

  localparam int DIV   = 10;
  localparam int MSG   = 30 * DIV;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, ev_valid, ev_on, ev_ready, midi_txd, busy;
  logic [6:0] ev_note, ev_velocity;
  logic [3:0] ev_channel;
  logic [2:0] fifo_level;

  logic       reset2, ev_valid2, ev_on2, ev_ready2, midi_txd2, busy2;
  logic [6:0] ev_note2, ev_velocity2;
  logic [3:0] ev_channel2;
  logic [2:0] fifo_level2;
  logic       dut2_done = 1'b0;

  midi_note_tx #(.CLK_FREQUENCY(312500), .BAUD(31250), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .ev_velocity(ev_velocity),
    .ev_channel(ev_channel), .midi_txd(midi_txd), .busy(busy),
    .fifo_level(fifo_level)
  );

  midi_note_tx #(.CLK_FREQUENCY(50_000_000), .BAUD(31250), .FIFO_DEPTH(DEPTH)) dut_rate (
    .clk(clk), .reset(reset2), .ev_valid(ev_valid2), .ev_ready(ev_ready2),
    .ev_on(ev_on2), .ev_note(ev_note2), .ev_velocity(ev_velocity2),
    .ev_channel(ev_channel2), .midi_txd(midi_txd2), .busy(busy2),
    .fifo_level(fifo_level2)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Each accepted event becomes one 30-bit-period message starting on the
  // edge after acceptance, or when the previous message ends if later.
  typedef struct {
    int          start;
    logic [23:0] bytes;
  } msg_t;

  msg_t q[$];
  int   line_free = 0;
  int   cyc = 0;
  logic m_ready = 1'b0;
  logic accepted_last = 1'b0;

  function automatic logic line_bit(input logic [23:0] by, input int off);
    int bi;
    int pos;
    logic [7:0] b;
    bi  = off / (10 * DIV);
    pos = (off % (10 * DIV)) / DIV;
    b   = (bi == 0) ? by[23:16] : (bi == 1) ? by[15:8] : by[7:0];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic tick();
    int   lvl;
    logic bsy, txd;
    msg_t m;
    @(posedge clk);
    cyc++;
    accepted_last = 1'b0;
    if (reset) begin
      q.delete();
      line_free = 0;
    end else if (ev_valid && m_ready) begin
      m.start   = (cyc + 1 > line_free) ? cyc + 1 : line_free;
      line_free = m.start + MSG;
      m.bytes   = {(ev_on ? 4'h9 : 4'h8), ev_channel, 1'b0, ev_note, 1'b0, ev_velocity};
      q.push_back(m);
      accepted_last = 1'b1;
    end
    while (q.size() > 0 && q[0].start + MSG <= cyc) void'(q.pop_front());
    lvl = 0;
    bsy = 1'b0;
    txd = 1'b1;
    foreach (q[i]) begin
      bsy = 1'b1;
      if (q[i].start > cyc) lvl++;
      else txd = line_bit(q[i].bytes, cyc - q[i].start);
    end
    m_ready = (lvl != DEPTH);
    #1;
    chk("midi_txd", {31'd0, midi_txd}, {31'd0, txd});
    chk("busy", {31'd0, busy}, {31'd0, bsy});
    chk("fifo_level", {29'd0, fifo_level}, lvl);
    chk("ev_ready", {31'd0, ev_ready}, {31'd0, m_ready});
  endtask

  task automatic set_ev(input logic on, input logic [3:0] ch, input logic [6:0] note,
                        input logic [6:0] vel);
    ev_on = on;
    ev_channel = ch;
    ev_note = note;
    ev_velocity = vel;
  endtask

  task automatic set_rand_ev();
    set_ev(1'($urandom), 4'($urandom), 7'($urandom), 7'($urandom));
  endtask

  task automatic send_one();
    ev_valid = 1'b1;
    tick();
    ev_valid = 1'b0;
  endtask

  initial begin
    int nacc;
    reset = 1'b1;
    ev_valid = 1'b0;
    set_ev(1'b0, 4'd0, 7'd0, 7'd0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (100) tick();

    set_ev(1'b1, 4'd0, 7'h3C, 7'h64);
    send_one();
    repeat (310) tick();

    set_ev(1'b0, 4'd9, 7'h45, 7'h40);
    send_one();
    repeat (310) tick();

    nacc = 0;
    set_rand_ev();
    ev_valid = 1'b1;
    for (int i = 0; i < 1000 && nacc < 6; i++) begin
      tick();
      if (accepted_last) begin
        nacc++;
        set_rand_ev();
      end
    end
    ev_valid = 1'b0;
    chk("burst_accepts", nacc, 6);
    repeat (1900) tick();

    // reset lands in byte1 bit3 (offset 144 from the start bit)
    set_rand_ev();
    send_one();
    repeat (144) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (500) tick();
    set_rand_ev();
    send_one();
    repeat (310) tick();

    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 1999) == 0);
      ev_valid = ($urandom_range(0, 99) < 35);
      set_rand_ev();
      tick();
    end
    reset = 1'b0;
    ev_valid = 1'b0;
    repeat (1600) tick();

    for (int i = 0; i < 60000 && !dut2_done; i++) @(posedge clk);
    chk("rate_finished", {31'd0, dut2_done}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int t;
    reset2 = 1'b1;
    ev_valid2 = 1'b0;
    ev_on2 = 1'b1;
    ev_channel2 = 4'd1;
    ev_note2 = 7'h3C;
    ev_velocity2 = 7'h64;
    repeat (3) @(posedge clk);
    #1;
    reset2 = 1'b0;
    chk("rate_reset_txd", {31'd0, midi_txd2}, 32'd1);
    chk("rate_reset_busy", {31'd0, busy2}, 32'd0);
    ev_valid2 = 1'b1;
    @(posedge clk);
    #1;
    ev_valid2 = 1'b0;
    chk("rate_busy_on_accept", {31'd0, busy2}, 32'd1);
    @(posedge clk);
    #1;
    chk("rate_start_edge", {31'd0, midi_txd2}, 32'd0);
    t = 0;
    while (midi_txd2 == 1'b0 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("rate_start_len", t, 1600);
    while (busy2 && t < 50000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("rate_msg_len", t, 48000);
    dut2_done = 1'b1;
  end

endmodule
